oam_frame_scheduler: RTL and testbench
======================================

# oam_frame_scheduler

Per-frame sequencer between the tank and bullet engines and the sprite OAM. Once per video frame it issues the game-wide movement tick, waits for object logic to settle, and snapshots every object's 32-bit state word. It then streams the snapshot into OAM slots 0..N_OBJ-1 over a valid/ready write port. The OAM therefore always receives a coherent, tear-free set of object states.

## Interface
- N_OBJ, 8: number of object slots (tanks + bullets); OAM address = slot index
- ADDR_W, 3: OAM address width; must satisfy 2^ADDR_W >= N_OBJ
- MOVE_DIV, 4: enabled frames per movement tick; must be >= 1
- SETTLE_CYC, 2: cycles waited after TICK before snapshot; must be >= 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- enable  in  1  1 = game running (not game_over); gates move_tick and divider
- obj_state  in  32*N_OBJ  flattened state words; slot i = bits [32*i+31 : 32*i]
- obj_mask  in  N_OBJ  1 = slot i holds a live object
- move_tick  out  1  one-cycle movement strobe to all tanks/bullets
- oam_valid  out  1  write request
- oam_ready  in  1  OAM accepts write when high with oam_valid
- oam_addr  out  ADDR_W  slot being written
- oam_data  out  32  word being written
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse after last OAM write
- overrun  out  1  sticky: frame_start arrived while busy

## Operation
- States: IDLE, TICK, SETTLE, SNAP, COPY, DONE.
- IDLE: frame_start=1 -> TICK. Other inputs are ignored.
- TICK (1 cycle):
  - move_tick=1 iff enable=1 and frame_cnt==MOVE_DIV-1.
  - If enable=1: frame_cnt wraps to 0 when at MOVE_DIV-1, else increments.
  - If enable=0: frame_cnt holds.
  - Next state: SETTLE.
- SETTLE: counts SETTLE_CYC cycles, then -> SNAP.
- SNAP (1 cycle): latches obj_state and obj_mask into internal snapshot registers. idx <= 0. Next state: COPY.
- COPY:
  - oam_valid=1, oam_addr=idx.
  - oam_data = snapshot word idx if mask bit idx=1, else 32'h0. Masked-out slots are cleared, not skipped.
  - Transfer occurs on a cycle with oam_valid & oam_ready. idx then increments.
  - After transfer of idx==N_OBJ-1 -> DONE.
- DONE (1 cycle): frame_done=1. Next state: IDLE.
- Input changes after SNAP do not affect written data.
- MOVE_DIV=1: move_tick fires on every enabled frame.
- frame_cnt width = max(1, clog2(MOVE_DIV)); unsigned; wraps only via the explicit compare.

## Timing
- Reset (reset=0, async):
  - State -> IDLE immediately; frame_cnt=0, idx=0.
  - All outputs 0: move_tick, oam_valid, oam_addr, oam_data, busy, frame_done, overrun.
  - Reset mid-COPY aborts the frame. oam_valid drops without waiting for the handshake. No partial resume.
- Reset deassertion: takes effect on the next clk edge; the first frame_start after release is accepted.
- Latency, frame_start sampled high at edge E0, S=SETTLE_CYC:
  - Cycle 1: TICK.
  - Cycles 2..1+S: SETTLE.
  - Cycle 2+S: SNAP.
  - First oam_valid: cycle 3+S.
  - With oam_ready held at 1: writes occupy cycles 3+S..2+S+N_OBJ, frame_done at cycle 3+S+N_OBJ.
  - Defaults: busy cycles 1..13, frame_done cycle 13, total 13 cycles.
- Handshake:
  - While oam_valid=1 and oam_ready=0, oam_addr and oam_data stay stable and oam_valid stays high.
  - oam_valid never deasserts before acceptance, except on reset.
  - oam_ready has no combinational path to oam_valid. oam_valid is registered and depends only on state.
- Outputs are registered or decoded from state only: move_tick, busy, frame_done, oam_*.
- frame_start while busy (including the DONE cycle):
  - Ignored, and overrun <= 1.
  - overrun stays 1 until reset.
  - The frame in progress completes normally.
- frame_start in the same cycle that DONE -> IDLE: counts as busy, so it sets overrun.

## Test plan
- Basic frame, defaults, ready=1, enable=1, mask=8'hFF, slot i = 32'hA000_0000+i:
  - Four frame_starts -> move_tick only on the 4th frame (cycle 1 after its pulse).
  - Each frame writes addr 0..7 with data A000_0000..A000_0007.
  - frame_done at cycle 13.
- Backpressure: ready toggled 0,0,1 repeatedly -> each write is held stable for 3 cycles; frame_done at 3+2+24 = cycle 29; no addr/data change while ready=0.
- Mask and snapshot:
  - mask=8'b0000_0101 -> slots 0 and 2 carry data; slots 1 and 3..7 are written 32'h0.
  - Change obj_state during COPY -> written data equals the SNAP-cycle values.
- Enable gating: enable=0 for 3 frames, then 1 -> no move_tick while disabled; divider held; tick on the 4th enabled frame.
- Overrun: second frame_start during COPY -> overrun=1 and persists; current frame completes with 8 writes; no extra frame starts.
- Async reset mid-COPY after 3 writes, ready=1 -> outputs 0 immediately without a clock edge. Next frame_start restarts at addr 0 with frame_cnt=0.

Source files
------------

// File: rtl/oam_frame_scheduler.sv
// Per-frame sequencer: movement tick, settle wait, object-state snapshot, then stream snapshot to OAM slots.
// Latency: frame_start at edge E0 -> TICK cycle 1, SNAP cycle 2+SETTLE_CYC, writes from 3+SETTLE_CYC, frame_done after last write.
// Backpressure: oam_valid holds with stable addr/data until oam_ready; only reset can drop a pending write.
module oam_frame_scheduler #(
  parameter int N_OBJ      = 8,
  parameter int ADDR_W     = 3,
  parameter int MOVE_DIV   = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  enable,
  input  logic [32*N_OBJ-1:0]   obj_state,
  input  logic [N_OBJ-1:0]      obj_mask,
  output logic                  move_tick,
  output logic                  oam_valid,
  input  logic                  oam_ready,
  output logic [ADDR_W-1:0]     oam_addr,
  output logic [31:0]           oam_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int FC_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [FC_W-1:0]   DIV_LAST    = FC_W'(MOVE_DIV - 1);
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST    = ADDR_W'(N_OBJ - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TICK   = 3'd1,
    SETTLE = 3'd2,
    SNAP   = 3'd3,
    COPY   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                    state;
  logic [FC_W-1:0]           frame_cnt;
  logic [SC_W-1:0]           settle_cnt;
  logic [ADDR_W-1:0]         idx;
  logic [N_OBJ-1:0][31:0]    snap_words;
  logic [N_OBJ-1:0]          snap_mask;

  // Sequencer: state, counters, snapshot and all registered strobes advance together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      settle_cnt <= '0;
      idx        <= '0;
      snap_words <= '0;
      snap_mask  <= '0;
      move_tick  <= 1'b0;
      oam_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      move_tick  <= 1'b0;
      frame_done <= 1'b0;
      // A frame_start while any frame is in flight (DONE included) is dropped but remembered.
      if (frame_start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= TICK;
            busy  <= 1'b1;
            // Tick strobe is registered here so it is visible during the TICK cycle.
            if (enable) begin
              move_tick <= (frame_cnt == DIV_LAST);
              frame_cnt <= (frame_cnt == DIV_LAST) ? '0 : frame_cnt + 1'b1;
            end
          end
        end
        TICK: begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SNAP;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SNAP: begin
          snap_words <= obj_state;
          snap_mask  <= obj_mask;
          idx        <= '0;
          oam_valid  <= 1'b1;
          state      <= COPY;
        end
        COPY: begin
          if (oam_ready) begin
            if (idx == IDX_LAST) begin
              // Park idx at 0 so oam_addr reads 0 outside the copy phase.
              idx        <= '0;
              oam_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          oam_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Write port reflects the frozen snapshot; masked-out slots are written as zero.
  always_comb begin
    oam_addr = idx;
    oam_data = 32'h0;
    if (oam_valid && snap_mask[idx]) begin
      oam_data = snap_words[idx];
    end
  end

endmodule

// File: tb/tb_oam_frame_scheduler.sv
// Bench for oam_frame_scheduler: directed scenarios plus randomized frames against a timeline model.
// Model tracks cycles since frame acceptance and writes accepted; outputs compared every cycle.
// Hand-computed literals pin frame length, tick cadence, written data and async reset behaviour.
module tb_oam_frame_scheduler;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int MD = 4;
  localparam int S  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start;
  logic             enable;
  logic [32*N-1:0]  obj_state;
  logic [N-1:0]     obj_mask;
  logic             move_tick;
  logic             oam_valid;
  logic             oam_ready;
  logic [AW-1:0]    oam_addr;
  logic [31:0]      oam_data;
  logic             busy;
  logic             frame_done;
  logic             overrun;

  oam_frame_scheduler #(.N_OBJ(N), .ADDR_W(AW), .MOVE_DIV(MD), .SETTLE_CYC(S)) dut (
    .clk(clk), .reset(rst_n), .frame_start(frame_start), .enable(enable),
    .obj_state(obj_state), .obj_mask(obj_mask), .move_tick(move_tick),
    .oam_valid(oam_valid), .oam_ready(oam_ready), .oam_addr(oam_addr),
    .oam_data(oam_data), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline reference model ----------------
  bit          m_active, m_done, m_ovr, m_tick_frame;
  int          m_t, m_div, m_wr;
  logic [31:0] m_snap [N];
  logic [N-1:0] m_mask;
  logic        e_tick, e_valid, e_busy, e_done, e_ovr;
  logic [AW-1:0] e_addr;
  logic [31:0] e_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_ovr = 0; m_tick_frame = 0;
      m_t = 0; m_div = 0; m_wr = 0;
    end else if (m_active) begin
      if (frame_start) m_ovr = 1;
      if (m_done) begin
        m_active = 0;
      end else begin
        if (m_t == 2 + S) begin
          for (int i = 0; i < N; i++) m_snap[i] = obj_state[32*i +: 32];
          m_mask = obj_mask;
          m_wr = 0;
        end else if (m_t >= 3 + S && m_wr < N && oam_ready) begin
          m_wr++;
          if (m_wr == N) m_done = 1;
        end
        m_t++;
      end
    end else if (frame_start) begin
      m_active = 1; m_t = 1; m_wr = 0; m_done = 0;
      m_tick_frame = enable && (m_div == MD - 1);
      if (enable) m_div = (m_div + 1) % MD;
    end
    e_busy  = m_active;
    e_tick  = m_active && m_t == 1 && m_tick_frame;
    e_valid = m_active && !m_done && m_t >= 3 + S && m_wr < N;
    e_done  = m_active && m_done;
    e_ovr   = m_ovr;
    e_addr  = e_valid ? m_wr[AW-1:0] : '0;
    e_data  = (e_valid && m_mask[m_wr]) ? m_snap[m_wr] : 32'h0;
  end

  // ---------------- compare + monitor ----------------
  bit          chk_on = 0;
  int          busy_run = 0, done_at = 0, tick_cnt = 0;
  logic [AW-1:0] wr_a [$];
  logic [31:0] wr_d [$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("move_tick",  32'(move_tick),  32'(e_tick));
      check("oam_valid",  32'(oam_valid),  32'(e_valid));
      check("oam_addr",   32'(oam_addr),   32'(e_addr));
      check("oam_data",   oam_data,        e_data);
      check("busy",       32'(busy),       32'(e_busy));
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("overrun",    32'(overrun),    32'(e_ovr));
    end
    if (busy) busy_run++; else busy_run = 0;
    if (frame_done) done_at = busy_run;
    if (move_tick) tick_cnt++;
    if (oam_valid && oam_ready) begin
      wr_a.push_back(oam_addr);
      wr_d.push_back(oam_data);
    end
  end

  // ---------------- OAM ready generator ----------------
  int rdy_mode = 0;
  int k = 0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1: begin
        if (oam_valid) begin
          oam_ready = (k % 3 == 2);
          k++;
        end else begin
          oam_ready = 1'b0;
          k = 0;
        end
      end
      2: oam_ready = 1'($urandom_range(0, 1));
      default: oam_ready = 1'b1;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_d.delete();
    tick_cnt = 0;
    done_at = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_frame();
    clear_mon();
    pulse();
    wait_idle();
    tick();
  endtask

  logic [31:0] saved [N];

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; enable = 1'b1; oam_ready = 1'b1;
    obj_mask = '1;
    for (int i = 0; i < N; i++) obj_state[32*i +: 32] = 32'hA000_0000 + i;
    tick(); tick();
    check("reset_busy",    32'(busy),      32'd0);
    check("reset_valid",   32'(oam_valid), 32'd0);
    check("reset_overrun", 32'(overrun),   32'd0);
    chk_on = 1;
    rst_n = 1'b1;
    tick();

    // Basic frames: tick only on the 4th, 13-cycle frames, linear data.
    for (int f = 0; f < 4; f++) begin
      run_frame();
      check("basic_done_at", 32'(done_at), 32'd13);
      check("basic_ticks", 32'(tick_cnt), (f == 3) ? 32'd1 : 32'd0);
      check("basic_nwr", 32'(wr_a.size()), 32'd8);
      if (wr_a.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          check("basic_addr", 32'(wr_a[i]), 32'(i));
          check("basic_data", wr_d[i], 32'hA000_0000 + 32'(i));
        end
      end
    end

    // Enable gating: divider frozen while disabled.
    enable = 1'b0;
    for (int f = 0; f < 3; f++) begin
      run_frame();
      check("dis_ticks", 32'(tick_cnt), 32'd0);
    end
    enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_frame();
      check("en_ticks", 32'(tick_cnt), (f == 3) ? 32'd1 : 32'd0);
    end

    // Backpressure 0,0,1.
    rdy_mode = 1;
    run_frame();
    check("bp_done_at", 32'(done_at), 32'd29);
    check("bp_nwr", 32'(wr_a.size()), 32'd8);
    rdy_mode = 0;
    tick();

    // Mask + snapshot coherence.
    obj_mask = 8'b0000_0101;
    for (int i = 0; i < N; i++) begin
      saved[i] = $urandom;
      obj_state[32*i +: 32] = saved[i];
    end
    clear_mon();
    pulse();
    repeat (5) tick();
    for (int i = 0; i < N; i++) obj_state[32*i +: 32] = $urandom;
    wait_idle();
    tick();
    check("mask_nwr", 32'(wr_a.size()), 32'd8);
    if (wr_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("mask_data", wr_d[i], (i == 0 || i == 2) ? saved[i] : 32'h0);
      end
    end
    obj_mask = '1;

    // Overrun: second frame_start during COPY.
    clear_mon();
    pulse();
    repeat (6) tick();
    pulse();
    wait_idle();
    tick();
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_nwr", 32'(wr_a.size()), 32'd8);
    repeat (20) tick();
    check("ovr_no_extra", 32'(busy), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Async reset mid-COPY after three writes.
    clear_mon();
    pulse();
    repeat (7) tick();
    check("rst_pre_addr", 32'(oam_addr), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(oam_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_addr",  32'(oam_addr),  32'd0);
    check("rst_data",  oam_data,       32'h0);
    check("rst_ovr",   32'(overrun),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int f = 0; f < 4; f++) begin
      run_frame();
      check("post_rst_ticks", 32'(tick_cnt), (f == 3) ? 32'd1 : 32'd0);
      if (f == 0 && wr_a.size() > 0) check("post_rst_addr0", 32'(wr_a[0]), 32'd0);
    end

    // Randomized frames with random ready, stray frame_starts, churning inputs.
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      enable = 1'($urandom_range(0, 1));
      obj_mask = N'($urandom);
      for (int i = 0; i < N; i++) obj_state[32*i +: 32] = $urandom;
      pulse();
      for (int c = 0; c < 300 && busy; c++) begin
        obj_state[32*$urandom_range(0, N-1) +: 32] = $urandom;
        frame_start = ($urandom_range(0, 19) == 0);
        tick();
      end
      frame_start = 1'b0;
      check("rand_idle", 32'(busy), 32'd0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rdy_mode = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
